load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store initiator between the CPU datapath and the word-organised `data_memory`. It accepts one byte-addressed RV32I load or store per transaction (lb/lh/lw/lbu/lhu/sb/sh/sw) and translates it into word accesses on the memory port. Sub-word stores use read-modify-write because the memory has no byte enables. Faults for misalignment, bad Funct3 and out-of-range addresses are reported without touching memory.

## Interface
- `MEMORY_SIZE`, default 64: number of 32-bit words in the attached data memory.
- `CLK` in 1: rising-edge clock.
- `RESET_N` in 1: asynchronous, active-low reset.
- `Start` in 1: request valid; sampled only while `Ready`=1.
- `IsStore` in 1: 1 = store, 0 = load.
- `Funct3` in 3: RV32I width/sign code.
- `Address` in 32: byte address.
- `StoreData` in 32: store source; the low byte/half is used for sb/sh.
- `Ready` out 1: unit idle; a request is accepted on this edge if `Start`=1.
- `Done` out 1: one-cycle completion pulse.
- `Fault` out 1: valid with `Done`; 1 = request rejected.
- `LoadData` out 32: extended load result; holds until the next successful load.
- `MemWriteEnable` out 1: drives memory WriteEnable.
- `MemAddress` out 32: word index, equal to `Address[31:2]` zero-extended.
- `MemWriteData` out 32: full word to write.
- `MemReadData` in 32: memory read data; registered one cycle after an edge with WriteEnable=0.

## Operation
- FSM states: IDLE, READ, CAPTURE, WRITE, DONE. `Ready` = (state==IDLE). `Done` = (state==DONE). All outputs are Moore outputs from registers.
- Accept edge: on IDLE with `Start`=1, latch the request and set `MemAddress`=`Address[31:2]`.
- Fault conditions:
  - Loads: Funct3 ∉ {000,001,010,100,101}.
  - Stores: Funct3 ∉ {000,001,010}.
  - Halfword access with `Address[0]`=1.
  - Word access with `Address[1:0]`≠0.
  - Word index ≥ `MEMORY_SIZE`.
- A faulting request goes IDLE→DONE with `Fault`=1. There is no memory access and `LoadData` is unchanged.
- Load path: IDLE→READ→CAPTURE→DONE→IDLE.
  - In CAPTURE, `MemReadData` is valid.
  - The byte/half is selected by `Address[1:0]`, little-endian: byte k occupies bits [8k+7:8k].
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - The result is registered into `LoadData` on the CAPTURE→DONE edge.
- sw path: IDLE→WRITE→DONE. `MemWriteData`=`StoreData`.
- sb/sh path: IDLE→READ→CAPTURE→WRITE→DONE.
  - On the CAPTURE→WRITE edge, `MemWriteData` is registered as `MemReadData` with only the addressed byte/half replaced.
- `MemWriteEnable`=1 only in WRITE.
- In READ and CAPTURE, `MemWriteEnable`=0 and `MemAddress` is held.
- `Start` is ignored in every state except IDLE. DONE always returns to IDLE, so back-to-back requests are separated by one IDLE cycle.

## Timing
- Reset values: state=IDLE, `Ready`=1, `Done`=0, `Fault`=0, `LoadData`=0, `MemWriteEnable`=0, `MemAddress`=0, `MemWriteData`=0.
- Latency, counted as the cycle in which `Done`=1 after the accept edge (cycle 0):
  - Fault: 1.
  - sw: 2.
  - Load: 3.
  - sb/sh: 4.
- Reset mid-operation: `RESET_N` low forces IDLE and all reset values asynchronously. `MemWriteEnable` drops immediately, so an in-flight WRITE is abandoned and no partial word is written. A pending load produces no `Done`.
- Address wrap: only `Address[31:2]` is forwarded. `Address[1:0]` selects lanes and is never added to the index.

## Structure
- Shared package `lsu_pkg`:
  - Funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enumeration: IDLE, READ, CAPTURE, WRITE, DONE.
- Sub-module `lsu_align`: purely combinational.
  - Load extraction: word, offset, funct3 → 32-bit result.
  - Store merge: old word, new data, offset, funct3 → 32-bit word.
  - Reused for both paths; the FSM stays in `load_store_unit`.

## Test plan
- sw then lw: `Address`=0x10, `StoreData`=0xDEADBEEF.
  - sw: `MemAddress`=4 and WE=1 in cycle 1; `Done` in cycle 2.
  - lw: `LoadData`=0xDEADBEEF with `Done` in cycle 3.
- Word 5 = 0x11223344; sb 0xAA at `Address`=0x15. Memory becomes 0x1122AA44; exactly one WE cycle; `Done` in cycle 4.
- Word 5 = 0x8000FF7F.
  - lb at 0x14 → 0x0000007F.
  - lb at 0x15 → 0xFFFFFFFF.
  - lbu at 0x15 → 0x000000FF.
  - lh at 0x16 → 0xFFFF8000.
  - lhu at 0x16 → 0x00008000.
- Each of the following gives `Fault`=1 and `Done` in cycle 1, with WE never asserted and `LoadData` unchanged:
  - lw at 0x13.
  - sh at 0x01.
  - Funct3=011 load.
  - Any access at 0x100 with `MEMORY_SIZE`=64.
- sb started, then `RESET_N` pulsed low during WRITE: WE falls in the same cycle, memory is unchanged, `Ready`=1, and no `Done` occurs.
- `Start` held high continuously: requests are accepted only on IDLE edges, and `Done` pulses never overlap.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes,
// FSM state encoding, and the request legality check (funct3 + alignment).
// Pure package: no latency, no flow control.
package lsu_pkg;

    // RV32I load/store width codes (funct3 field)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } lsu_state_t;

    // Flags a request whose width code is illegal for its direction or whose
    // byte offset is not naturally aligned for that width. The address range
    // check lives in the top level because it depends on the memory size.
    function automatic logic req_bad_form(
        input logic       is_store,
        input logic [2:0] funct3,
        input logic [1:0] offset
    );
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = is_store;              // no unsigned store
            F3_H:    bad = offset[0];
            F3_HU:   bad = is_store | offset[0];
            F3_W:    bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering between a 32-bit memory word and byte/half/word data.
// Purely combinational (zero latency); no flow control.
// Ports: rd_word/offset/funct3 -> load_val (extracted + extended);
//        rd_word/wr_data/offset/funct3 -> store_word (read-modify-write merge).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_data,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Little-endian lanes: byte k lives in bits [8k+7:8k]
    always_comb begin
        sel_byte = rd_word[7:0];
        case (offset)
            2'd0: sel_byte = rd_word[7:0];
            2'd1: sel_byte = rd_word[15:8];
            2'd2: sel_byte = rd_word[23:16];
            2'd3: sel_byte = rd_word[31:24];
            default: sel_byte = rd_word[7:0];
        endcase
        sel_half = offset[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        load_val = rd_word;
        case (funct3)
            F3_B:    load_val = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_val = {24'h000000, sel_byte};
            F3_H:    load_val = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_val = {16'h0000, sel_half};
            default: load_val = rd_word;
        endcase
    end

    // Old word with only the addressed lane(s) replaced by the new data
    always_comb begin
        store_word = rd_word;
        case (funct3)
            F3_B: begin
                case (offset)
                    2'd0: store_word[7:0]   = wr_data[7:0];
                    2'd1: store_word[15:8]  = wr_data[7:0];
                    2'd2: store_word[23:16] = wr_data[7:0];
                    2'd3: store_word[31:24] = wr_data[7:0];
                    default: store_word = rd_word;
                endcase
            end
            F3_H: begin
                if (offset[1]) store_word[31:16] = wr_data[15:0];
                else           store_word[15:0]  = wr_data[15:0];
            end
            default: store_word = wr_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed RV32I load/store initiator onto a word memory with 1-cycle
// registered reads; sub-word stores use read-modify-write.
// Latency (accept edge = cycle 0, Done cycle): fault 1, sw 2, load 3, sb/sh 4.
// Backpressure: one transaction at a time; Start is only sampled while Ready=1.
// Ports: CLK/RESET_N; request Start/IsStore/Funct3/Address/StoreData;
//        status Ready/Done/Fault/LoadData; memory MemWriteEnable/MemAddress/
//        MemWriteData/MemReadData.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEMORY_SIZE = 64
)
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        Start,
    input  logic        IsStore,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Address,
    input  logic [31:0] StoreData,
    output logic        Ready,
    output logic        Done,
    output logic        Fault,
    output logic [31:0] LoadData,
    output logic        MemWriteEnable,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    input  logic [31:0] MemReadData
);

    localparam logic [31:0] MEM_WORDS = 32'(MEMORY_SIZE);

    lsu_state_t  state;
    lsu_state_t  state_nxt;

    // Latched request
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] store_data_q;

    logic [31:0] req_idx;
    logic        req_fault;
    logic        accept;
    logic [31:0] align_load;
    logic [31:0] align_store;

    // Only Address[31:2] indexes memory; the low bits select lanes and are
    // never carried into the word index.
    assign req_idx   = {2'b00, Address[31:2]};
    assign req_fault = req_bad_form(IsStore, Funct3, Address[1:0])
                     | (req_idx >= MEM_WORDS);
    assign accept    = (state == IDLE) && Start;

    lsu_align u_align (
        .rd_word    (MemReadData),
        .wr_data    (store_data_q),
        .offset     (offset_q),
        .funct3     (funct3_q),
        .load_val   (align_load),
        .store_word (align_store)
    );

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (req_fault)                     state_nxt = DONE;
                    else if (IsStore && Funct3 == F3_W) state_nxt = WRITE;
                    else                               state_nxt = READ;
                end
            end
            // Memory registers the read on the READ->CAPTURE edge
            READ:    state_nxt = CAPTURE;
            CAPTURE: state_nxt = is_store_q ? WRITE : DONE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: all from the state register, so Moore and glitch-safe
    // relative to request inputs. Reset clears WriteEnable immediately.
    always_comb begin
        Ready          = (state == IDLE);
        Done           = (state == DONE);
        MemWriteEnable = (state == WRITE);
    end

    // Datapath registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            offset_q     <= 2'b00;
            store_data_q <= 32'h0;
            Fault        <= 1'b0;
            LoadData     <= 32'h0;
            MemAddress   <= 32'h0;
            MemWriteData <= 32'h0;
        end else begin
            if (accept) begin
                is_store_q   <= IsStore;
                funct3_q     <= Funct3;
                offset_q     <= Address[1:0];
                store_data_q <= StoreData;
                Fault        <= req_fault;
                MemAddress   <= req_idx;
                // Full-word store skips the read, so its data is ready now
                if (!req_fault && IsStore && Funct3 == F3_W) begin
                    MemWriteData <= StoreData;
                end
            end
            if (state == CAPTURE) begin
                if (is_store_q) MemWriteData <= align_store;
                else            LoadData     <= align_load;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int MEM_WORDS = 64;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        Start;
    logic        IsStore;
    logic [2:0]  Funct3;
    logic [31:0] Address;
    logic [31:0] StoreData;
    logic        Ready;
    logic        Done;
    logic        Fault;
    logic [31:0] LoadData;
    logic        MemWriteEnable;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic [31:0] MemReadData;

    load_store_unit #(.MEMORY_SIZE(MEM_WORDS)) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .Start          (Start),
        .IsStore        (IsStore),
        .Funct3         (Funct3),
        .Address        (Address),
        .StoreData      (StoreData),
        .Ready          (Ready),
        .Done           (Done),
        .Fault          (Fault),
        .LoadData       (LoadData),
        .MemWriteEnable (MemWriteEnable),
        .MemAddress     (MemAddress),
        .MemWriteData   (MemWriteData),
        .MemReadData    (MemReadData)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Word memory with registered read; backdoor port for presetting words
    logic [31:0] mem [0:MEM_WORDS-1];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_idx = 6'd0;
    logic [31:0] bd_dat = 32'h0;

    always @(posedge CLK) begin
        if (bd_we) mem[bd_idx] <= bd_dat;
        else if (MemWriteEnable && MemAddress < MEM_WORDS) mem[MemAddress[5:0]] <= MemWriteData;
        MemReadData <= (MemAddress < MEM_WORDS) ? mem[MemAddress[5:0]] : 32'h0;
    end

    // Reference model state
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    logic [31:0] ref_last_ld = 32'h0;

    typedef struct {
        bit          fault;
        logic [31:0] ld;
        int          lat;
        int          we;
        logic [31:0] idx;
        int          t_acc;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit ok_f3;
        ok_f3 = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!ok_f3) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
        if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
        if ((a >> 2) >= MEM_WORDS) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] s, b, h;
        s = w >> (8 * off);
        b = s & 32'hFF;
        h = s & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] mask;
        mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFFFFFF;
        return (w & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
    endfunction

    // Drive a request this (negedge) cycle and push its expected outcome
    task automatic drive_req(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        logic [5:0] i;
        bit flt;
        Start = 1'b1; IsStore = st; Funct3 = f3; Address = a; StoreData = d;
        flt     = ref_fault(st, f3, a);
        e.fault = flt;
        e.idx   = a >> 2;
        e.t_acc = cyc;
        e.we    = (!flt && st) ? 1 : 0;
        if (flt)     e.lat = 1;
        else if (st) e.lat = (f3 == 3'd2) ? 2 : 4;
        else         e.lat = 3;
        i = a[7:2];
        if (!flt) begin
            if (st) ref_mem[i] = ref_store(ref_mem[i], d, a[1:0], f3);
            else    ref_last_ld = ref_load(ref_mem[i], a[1:0], f3);
        end
        e.ld = ref_last_ld;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (Ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL ready_timeout: Ready stayed 0, expected 1");
        end
    endtask

    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bit ok;
        wait_ready(ok);
        if (ok) begin
            drive_req(st, f3, a, d);
            @(posedge CLK);
            #1 Start = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin @(negedge CLK); k++; end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge CLK);
    endtask

    task automatic bd_write(input int idx, input logic [31:0] d);
        @(negedge CLK);
        bd_we = 1'b1; bd_idx = idx[5:0]; bd_dat = d;
        ref_mem[idx] = d;
        @(posedge CLK);
        #1 bd_we = 1'b0;
    endtask

    task automatic rand_req(output bit st, output logic [2:0] f3, output logic [31:0] a, output logic [31:0] d);
        logic [2:0] good [5];
        good[0] = 3'd0; good[1] = 3'd1; good[2] = 3'd2; good[3] = 3'd4; good[4] = 3'd5;
        st = bit'($urandom_range(0, 1));
        f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : good[$urandom_range(0, 4)];
        a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
        d  = $urandom;
    endtask

    // Monitor / scoreboard
    exp_t mon_e;
    int   we_cnt    = 0;
    logic prev_done = 1'b0;

    always @(negedge CLK) begin
        if (!RESET_N) begin
            we_cnt    = 0;
            prev_done = 1'b0;
        end else begin
            if (MemWriteEnable) begin
                we_cnt++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: WE=1 at word %h with no request outstanding", MemAddress);
                end else begin
                    chk("write_addr", MemAddress, exp_q[0].idx);
                end
            end
            if (Done) begin
                chk("done_overlap", 32'(prev_done), 32'h0);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: Done=1 with no request outstanding");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("fault",    32'(Fault), 32'(mon_e.fault));
                    chk("loaddata", LoadData, mon_e.ld);
                    chk("latency",  32'(cyc - mon_e.t_acc), 32'(mon_e.lat));
                    chk("we_count", 32'(we_cnt), 32'(mon_e.we));
                end
                we_cnt = 0;
            end
            prev_done = Done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a, d, saved;
        bit          ok;

        RESET_N = 1'b0; Start = 1'b0; IsStore = 1'b0; Funct3 = 3'd0;
        Address = 32'h0; StoreData = 32'h0;
        repeat (3) @(negedge CLK);

        chk("rst_ready", 32'(Ready), 32'h1);
        chk("rst_done",  32'(Done), 32'h0);
        chk("rst_fault", 32'(Fault), 32'h0);
        chk("rst_loaddata", LoadData, 32'h0);
        chk("rst_we", 32'(MemWriteEnable), 32'h0);
        chk("rst_memaddr", MemAddress, 32'h0);
        chk("rst_memwdata", MemWriteData, 32'h0);
        RESET_N = 1'b1;

        for (int i = 0; i < MEM_WORDS; i++) bd_write(i, $urandom);

        // sw then lw
        issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        drain();
        chk("lw_value", LoadData, 32'hDEADBEEF);

        // sb read-modify-write
        bd_write(5, 32'h11223344);
        issue(1'b1, 3'd0, 32'h15, 32'h000000AA);
        drain();
        chk("sb_merge", mem[5], 32'h1122AA44);

        // Sub-word loads
        bd_write(5, 32'h8000FF7F);
        issue(1'b0, 3'd0, 32'h14, 32'h0); drain(); chk("lb_14",  LoadData, 32'h0000007F);
        issue(1'b0, 3'd0, 32'h15, 32'h0); drain(); chk("lb_15",  LoadData, 32'hFFFFFFFF);
        issue(1'b0, 3'd4, 32'h15, 32'h0); drain(); chk("lbu_15", LoadData, 32'h000000FF);
        issue(1'b0, 3'd1, 32'h16, 32'h0); drain(); chk("lh_16",  LoadData, 32'hFFFF8000);
        issue(1'b0, 3'd5, 32'h16, 32'h0); drain(); chk("lhu_16", LoadData, 32'h00008000);

        // Faults: no memory access, LoadData held
        issue(1'b0, 3'd2, 32'h13,  32'h0);
        issue(1'b1, 3'd1, 32'h01,  32'h1234);
        issue(1'b0, 3'd3, 32'h00,  32'h0);
        issue(1'b0, 3'd2, 32'h100, 32'h0);
        issue(1'b1, 3'd0, 32'h100, 32'h55);
        drain();
        chk("fault_ld_held", LoadData, 32'h00008000);

        // Reset during the WRITE of an sb
        bd_write(7, 32'hCAFEF00D);
        saved = ref_mem[7];
        wait_ready(ok);
        if (ok) begin
            drive_req(1'b1, 3'd0, 32'h1D, 32'h00000055);
            ref_mem[7] = saved;
            @(posedge CLK);
            #1 Start = 1'b0;
            ok = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge CLK);
                if (MemWriteEnable) begin ok = 1'b1; break; end
            end
            chk("rst_reached_write", 32'(ok), 32'h1);
            RESET_N = 1'b0;
            #1;
            chk("rst_we_drop", 32'(MemWriteEnable), 32'h0);
            chk("rst_mid_ready", 32'(Ready), 32'h1);
            chk("rst_mid_done", 32'(Done), 32'h0);
            @(posedge CLK);
            #1 chk("rst_mem_kept", mem[7], 32'hCAFEF00D);
            @(negedge CLK);
            exp_q.delete();
            ref_last_ld = 32'h0;
            RESET_N = 1'b1;
            repeat (6) @(negedge CLK);
            chk("rst_loaddata_clr", LoadData, 32'h0);
        end

        // Start held high: accepts only happen while Ready
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (Ready) begin
                rand_req(st, f3, a, d);
                drive_req(st, f3, a, d);
            end
        end
        @(posedge CLK);
        #1 Start = 1'b0;
        drain();

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            rand_req(st, f3, a, d);
            issue(st, f3, a, d);
        end
        drain();

        for (int i = 0; i < MEM_WORDS; i++) chk("mem_final", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
